// File: rtl/uart_tx_frame.sv
// uart_tx_frame: serialises one word per valid/ready handshake into an
// asynchronous frame (start bit, DataBits LSB-first, StopBits stop bits).
//
// Handshake: a word is transferred on a rising clock edge where valid and
// ready are both high. ready is high exactly while the FSM is IDLE. Upstream
// holds valid (and data) until it sees ready; valid while busy is ignored and
// there is no buffering.
module uart_tx_frame #(
    parameter int ClockFrequency = 1000000,
    parameter int BaudRate       = 9600,
    parameter int DataBits       = 8,
    parameter int StopBits       = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [DataBits-1:0] data,
    input  logic                valid,
    output logic                ready,
    output logic                done,
    output logic                tx,
    output logic [1:0]          state_dbg
);

    localparam int ClocksPerBit = ClockFrequency / BaudRate;
    localparam int TimerW       = (ClocksPerBit > 1) ? $clog2(ClocksPerBit) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              state;
    logic [TimerW-1:0]   timer;
    logic [3:0]          bit_idx;
    logic [DataBits-1:0] shift;
    logic                bit_end;

    // Terminal count of the per-bit timer; every bit boundary hangs off this.
    assign bit_end   = (timer == TimerW'(ClocksPerBit - 1));
    assign ready     = (state == IDLE);
    assign state_dbg = state;

    // Frame sequencer: owns the line, the bit timer, the bit/stop index and
    // the shift register; done is a registered one-cycle pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            done    <= 1'b0;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (valid) begin
                        shift   <= data;
                        timer   <= '0;
                        bit_idx <= '0;
                        tx      <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        tx      <= shift[0];
                        state   <= DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (bit_idx == 4'(DataBits - 1)) begin
                            // Stop index reuses bit_idx, counting stop periods.
                            bit_idx <= '0;
                            tx      <= 1'b1;
                            state   <= STOP;
                        end else begin
                            // Next line bit is the one about to land in shift[0].
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (bit_idx == 4'(StopBits - 1)) begin
                            bit_idx <= '0;
                            done    <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed test of uart_tx_frame with a per-cycle frame
// model (expected line queue) for two configurations: 8N1 and 7 data / 2 stop,
// both at 4 clocks per bit.
module tb_uart_tx_frame;

    localparam int Cpb = 4;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset;
    logic [7:0] data_a;
    logic       valid_a;
    logic       ready_a, done_a, tx_a;
    logic [1:0] st_a;
    logic [6:0] data_b;
    logic       valid_b;
    logic       ready_b, done_b, tx_b;
    logic [1:0] st_b;

    int checks = 0;
    int errors = 0;

    uart_tx_frame #(.ClockFrequency(1000000), .BaudRate(250000), .DataBits(8), .StopBits(1)) dut_a (
        .clock(clock), .reset(reset), .data(data_a), .valid(valid_a),
        .ready(ready_a), .done(done_a), .tx(tx_a), .state_dbg(st_a)
    );

    uart_tx_frame #(.ClockFrequency(1000000), .BaudRate(250000), .DataBits(7), .StopBits(2)) dut_b (
        .clock(clock), .reset(reset), .data(data_b), .valid(valid_b),
        .ready(ready_b), .done(done_b), .tx(tx_b), .state_dbg(st_b)
    );

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard / model ----------------
    // Line value of bit slot s in a frame: slot 0 start, then data LSB-first, then stop.
    function automatic logic frame_bit(input logic [8:0] d, input int nd, input int slot);
        if (slot == 0) return 1'b0;
        if (slot <= nd) return d[slot-1];
        return 1'b1;
    endfunction

    // Entries are {ready, done, tx} for each cycle after an edge.
    logic [2:0] exp_q_a[$];
    logic [2:0] exp_q_b[$];
    logic [2:0] cur_a = 3'b101;
    logic [2:0] cur_b = 3'b101;

    always @(posedge clock) begin
        if (reset) begin
            if (exp_q_a.size() == 0 && valid_a) begin
                for (int c = 0; c < (1 + 8 + 1) * Cpb; c++)
                    exp_q_a.push_back({2'b00, frame_bit({1'b0, data_a}, 8, c / Cpb)});
                exp_q_a.push_back(3'b111);
            end
            if (exp_q_a.size() > 0) cur_a = exp_q_a.pop_front();
            else cur_a = 3'b101;
            if (exp_q_b.size() == 0 && valid_b) begin
                for (int c = 0; c < (1 + 7 + 2) * Cpb; c++)
                    exp_q_b.push_back({2'b00, frame_bit({2'b00, data_b}, 7, c / Cpb)});
                exp_q_b.push_back(3'b111);
            end
            if (exp_q_b.size() > 0) cur_b = exp_q_b.pop_front();
            else cur_b = 3'b101;
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clock) begin
        if (!reset) begin
            exp_q_a.delete();
            exp_q_b.delete();
            cur_a = 3'b101;
            cur_b = 3'b101;
        end
        check("line_a", {13'd0, ready_a, done_a, tx_a}, {13'd0, cur_a});
        check("line_b", {13'd0, ready_b, done_b, tx_b}, {13'd0, cur_b});
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    // Sends one word on instance A and pins the frame against a hand-written
    // slot pattern. With inject set, data/valid are disturbed mid-frame.
    task automatic send_a(input logic [7:0] d, input logic [9:0] pat, input bit inject, input string nm);
        logic txh[42];
        int   low;
        int   dcnt;
        int   dcyc;
        low  = 0;
        dcnt = 0;
        dcyc = -1;
        data_a  = d;
        valid_a = 1'b1;
        for (int k = 0; k < 42; k++) begin
            @(posedge clock);
            #2;
            if (k == 0) valid_a = 1'b0;
            if (inject && k == 10) begin
                data_a  = ~d;
                valid_a = 1'b1;
            end
            if (inject && k == 11) valid_a = 1'b0;
            txh[k] = tx_a;
            if (!ready_a) low++;
            if (done_a) begin
                dcnt++;
                dcyc = k;
            end
        end
        for (int i = 0; i < 10; i++)
            check($sformatf("%s_slot%0d", nm, i), {15'd0, txh[4*i+2]}, {15'd0, pat[i]});
        check({nm, "_ready_low"}, 16'(low), 16'd40);
        check({nm, "_done_cnt"}, 16'(dcnt), 16'd1);
        check({nm, "_done_cyc"}, 16'(dcyc), 16'd40);
        tick(5);
        check({nm, "_idle_ready"}, {15'd0, ready_a}, 16'd1);
        check({nm, "_idle_tx"}, {15'd0, tx_a}, 16'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic txh2[200];
        int   dat[2];
        int   dcnt;
        logic txb[42];
        int   lowb;
        int   dcb;
        reset   = 1'b0;
        valid_a = 1'b0;
        data_a  = 8'h00;
        valid_b = 1'b0;
        data_b  = 7'h00;

        // Reset state
        tick(5);
        check("rst_tx", {15'd0, tx_a}, 16'd1);
        check("rst_ready", {15'd0, ready_a}, 16'd1);
        check("rst_done", {15'd0, done_a}, 16'd0);
        reset = 1'b1;
        tick(5);
        check("idle_ready", {15'd0, ready_a}, 16'd1);
        check("idle_tx", {15'd0, tx_a}, 16'd1);

        // Single frame 0xA5
        send_a(8'hA5, 10'b1101001010, 1'b0, "a5");

        // Back-to-back 0x00 then 0xFF with valid held high
        dcnt    = 0;
        dat[0]  = 0;
        dat[1]  = 0;
        data_a  = 8'h00;
        valid_a = 1'b1;
        for (int k = 0; k < 200 && dcnt < 2; k++) begin
            @(posedge clock);
            #2;
            txh2[k] = tx_a;
            if (done_a) begin
                dat[dcnt] = k;
                dcnt++;
                if (dcnt == 1) data_a = 8'hFF;
            end
        end
        valid_a = 1'b0;
        check("b2b_done_cnt", 16'(dcnt), 16'd2);
        if (dcnt == 2) begin
            for (int i = 0; i < 10; i++) begin
                check($sformatf("b2b_f1_slot%0d", i), {15'd0, txh2[4*i+2]}, (i == 9) ? 16'd1 : 16'd0);
                check($sformatf("b2b_f2_slot%0d", i), {15'd0, txh2[dat[0]+1+4*i+2]}, (i == 0) ? 16'd0 : 16'd1);
            end
        end
        tick(5);

        // Ignored inputs during DATA
        send_a(8'h3C, 10'b1001111000, 1'b1, "ign");

        // Mid-frame reset
        data_a  = 8'h55;
        valid_a = 1'b1;
        tick(1);
        valid_a = 1'b0;
        tick(17);
        reset = 1'b0;
        #1;
        check("mid_rst_tx", {15'd0, tx_a}, 16'd1);
        check("mid_rst_done", {15'd0, done_a}, 16'd0);
        check("mid_rst_ready", {15'd0, ready_a}, 16'd1);
        tick(3);
        check("mid_rst_hold_done", {15'd0, done_a}, 16'd0);
        reset = 1'b1;
        tick(2);
        check("post_rst_ready", {15'd0, ready_a}, 16'd1);
        send_a(8'h0F, 10'b1000011110, 1'b0, "0f");

        // Parameter corner: 7 data bits, 2 stop bits, data 0x7F
        lowb    = 0;
        dcb     = -1;
        data_b  = 7'h7F;
        valid_b = 1'b1;
        for (int k = 0; k < 42; k++) begin
            @(posedge clock);
            #2;
            if (k == 0) valid_b = 1'b0;
            txb[k] = tx_b;
            if (!ready_b) lowb++;
            if (done_b) dcb = k;
        end
        for (int i = 0; i < 10; i++)
            check($sformatf("c72_slot%0d", i), {15'd0, txb[4*i+2]}, (i == 0) ? 16'd0 : 16'd1);
        check("c72_ready_low", 16'(lowb), 16'd40);
        check("c72_done_cyc", 16'(dcb), 16'd40);
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
